// File: rtl/ctrl_pkg.sv
// Shared constants and control-word layout for the hardwired control unit.
package ctrl_pkg;

    localparam int unsigned ST_W = 4;

    localparam logic [ST_W-1:0] ST_F_ADR  = 4'd0;
    localparam logic [ST_W-1:0] ST_F_WAIT = 4'd1;
    localparam logic [ST_W-1:0] ST_F_ISR  = 4'd2;
    localparam logic [ST_W-1:0] ST_DEC    = 4'd3;
    localparam logic [ST_W-1:0] ST_B0     = 4'd4;
    localparam logic [ST_W-1:0] ST_B1     = 4'd5;
    localparam logic [ST_W-1:0] ST_I0     = 4'd6;
    localparam logic [ST_W-1:0] ST_I1     = 4'd7;
    localparam logic [ST_W-1:0] ST_L0     = 4'd8;
    localparam logic [ST_W-1:0] ST_L1     = 4'd9;
    localparam logic [ST_W-1:0] ST_L2     = 4'd10;
    localparam logic [ST_W-1:0] ST_S0     = 4'd11;
    localparam logic [ST_W-1:0] ST_S1     = 4'd12;
    localparam logic [ST_W-1:0] ST_P0     = 4'd13;
    localparam logic [ST_W-1:0] ST_P1     = 4'd14;
    localparam logic [ST_W-1:0] ST_HALT   = 4'd15;

    localparam logic [3:0] OP_BR_MAX = 4'h8;
    localparam logic [3:0] OP_ADDI   = 4'h9;
    localparam logic [3:0] OP_LDS    = 4'hA;
    localparam logic [3:0] OP_STS    = 4'hB;
    localparam logic [3:0] OP_ADDSP  = 4'hC;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [2:0] FS_ADD  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_PASS = 3'b010;

    typedef struct packed {
        logic [2:0] funsel;
        logic lsp, lpc, lmdr, lmar, lisr, ly, wrr;
        logic tr, tsp, tpc, tmdr, tisr;
        logic spmar, pcmar, mdrz, mdrm;
        logic sflag, cc, mem_rd, mem_wr, halted;
    } ctrl_word_t;

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> datapath/memory bundle: ISR and mrdy in, control word out.
interface control_unit_if;
    logic [15:0] isr;
    logic        mrdy;
    logic [2:0]  funsel;
    logic [2:0]  rsel;
    logic lsp, lpc, lmdr, lmar, lisr, ly, wrr;
    logic tr, tsp, tpc, tmdr, tisr;
    logic spmar, pcmar, mdrz, mdrm;
    logic sflag, cc, mem_rd, mem_wr, halted, buserr;

    modport master (
        input  isr, mrdy,
        output funsel, rsel, lsp, lpc, lmdr, lmar, lisr, ly, wrr,
               tr, tsp, tpc, tmdr, tisr, spmar, pcmar, mdrz, mdrm,
               sflag, cc, mem_rd, mem_wr, halted, buserr
    );

    modport slave (
        output isr, mrdy,
        input  funsel, rsel, lsp, lpc, lmdr, lmar, lisr, ly, wrr,
               tr, tsp, tpc, tmdr, tisr, spmar, pcmar, mdrz, mdrm,
               sflag, cc, mem_rd, mem_wr, halted, buserr
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts mrdy-low cycles in a wait state; expired_o flags the last allowed cycle.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)     count_d = '0;
        else if (en_i) count_d = count_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    // Fires in the cycle that would make the TIMEOUT-th mrdy-low cycle
    assign expired_o = (TIMEOUT != 0) && en_i && (count_q == TW'(LAST));

endmodule

// File: rtl/control_unit.sv
// Hardwired control FSM for the 16-bit single-bus datapath, including the
// memory handshake with optional mrdy timeout.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 5
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master bus
);
    logic [ST_W-1:0] state_q, state_d;
    logic            buserr_q, buserr_d;
    ctrl_word_t      cw_c, cw_gated_c;
    logic            in_wait_c, expired_c;
    logic            isr_unused_c;

    assign in_wait_c    = (state_q == ST_F_WAIT) || (state_q == ST_L1) || (state_q == ST_S1);
    assign isr_unused_c = ^bus.isr[8:0];

    mem_wait_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (!in_wait_c),
        .en_i      (in_wait_c && !bus.mrdy),
        .expired_o (expired_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_F_ADR;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buserr_q <= buserr_d;
        end
    end

    // Next state and control word; wait states add the mrdy-qualified strobes
    always_comb begin
        cw_c     = '0;
        state_d  = state_q;
        buserr_d = buserr_q;
        case (state_q)
            ST_F_ADR: begin
                cw_c.pcmar = 1'b1; cw_c.lmar = 1'b1;
                state_d = ST_F_WAIT;
            end
            ST_F_WAIT: begin
                cw_c.mem_rd = 1'b1;
                if (bus.mrdy) begin
                    cw_c.mdrm = 1'b1; cw_c.lmdr = 1'b1;
                    state_d = ST_F_ISR;
                end else if (expired_c) begin
                    state_d = ST_HALT; buserr_d = 1'b1;
                end
            end
            ST_F_ISR: begin
                cw_c.lisr = 1'b1; cw_c.tpc = 1'b1; cw_c.lpc = 1'b1;
                cw_c.funsel = FS_INC;
                state_d = ST_DEC;
            end
            ST_DEC: begin
                if (bus.isr[15:12] <= OP_BR_MAX) state_d = ST_B0;
                else begin
                    case (bus.isr[15:12])
                        OP_ADDI:  state_d = ST_I0;
                        OP_LDS:   state_d = ST_L0;
                        OP_STS:   state_d = ST_S0;
                        OP_ADDSP: state_d = ST_P0;
                        OP_HALT:  state_d = ST_HALT;
                        default:  state_d = ST_F_ADR;
                    endcase
                end
            end
            ST_B0: begin
                cw_c.tpc = 1'b1; cw_c.ly = 1'b1;
                state_d = ST_B1;
            end
            ST_B1: begin
                cw_c.tisr = 1'b1; cw_c.funsel = FS_ADD; cw_c.lpc = 1'b1; cw_c.cc = 1'b1;
                state_d = ST_F_ADR;
            end
            ST_I0: begin
                cw_c.tr = 1'b1; cw_c.ly = 1'b1;
                state_d = ST_I1;
            end
            ST_I1: begin
                cw_c.tisr = 1'b1; cw_c.funsel = FS_ADD; cw_c.wrr = 1'b1; cw_c.sflag = 1'b1;
                state_d = ST_F_ADR;
            end
            ST_L0: begin
                cw_c.spmar = 1'b1; cw_c.lmar = 1'b1;
                state_d = ST_L1;
            end
            ST_L1: begin
                cw_c.mem_rd = 1'b1;
                if (bus.mrdy) begin
                    cw_c.mdrm = 1'b1; cw_c.lmdr = 1'b1;
                    state_d = ST_L2;
                end else if (expired_c) begin
                    state_d = ST_HALT; buserr_d = 1'b1;
                end
            end
            ST_L2: begin
                cw_c.tmdr = 1'b1; cw_c.funsel = FS_PASS; cw_c.wrr = 1'b1;
                state_d = ST_F_ADR;
            end
            ST_S0: begin
                cw_c.tr = 1'b1; cw_c.funsel = FS_PASS; cw_c.mdrz = 1'b1; cw_c.lmdr = 1'b1;
                cw_c.spmar = 1'b1; cw_c.lmar = 1'b1;
                state_d = ST_S1;
            end
            ST_S1: begin
                cw_c.mem_wr = 1'b1;
                if (bus.mrdy) state_d = ST_F_ADR;
                else if (expired_c) begin
                    state_d = ST_HALT; buserr_d = 1'b1;
                end
            end
            ST_P0: begin
                cw_c.tsp = 1'b1; cw_c.ly = 1'b1;
                state_d = ST_P1;
            end
            ST_P1: begin
                cw_c.tisr = 1'b1; cw_c.funsel = FS_ADD; cw_c.lsp = 1'b1;
                state_d = ST_F_ADR;
            end
            ST_HALT: cw_c.halted = 1'b1;
            default: state_d = ST_F_ADR;
        endcase
    end

    // Everything reads zero while reset is held, including mid-wait requests
    assign cw_gated_c = reset ? '0 : cw_c;

    assign bus.funsel = cw_gated_c.funsel;
    assign bus.rsel   = reset ? 3'b000 : bus.isr[11:9];
    assign bus.lsp    = cw_gated_c.lsp;
    assign bus.lpc    = cw_gated_c.lpc;
    assign bus.lmdr   = cw_gated_c.lmdr;
    assign bus.lmar   = cw_gated_c.lmar;
    assign bus.lisr   = cw_gated_c.lisr;
    assign bus.ly     = cw_gated_c.ly;
    assign bus.wrr    = cw_gated_c.wrr;
    assign bus.tr     = cw_gated_c.tr;
    assign bus.tsp    = cw_gated_c.tsp;
    assign bus.tpc    = cw_gated_c.tpc;
    assign bus.tmdr   = cw_gated_c.tmdr;
    assign bus.tisr   = cw_gated_c.tisr;
    assign bus.spmar  = cw_gated_c.spmar;
    assign bus.pcmar  = cw_gated_c.pcmar;
    assign bus.mdrz   = cw_gated_c.mdrz;
    assign bus.mdrm   = cw_gated_c.mdrm;
    assign bus.sflag  = cw_gated_c.sflag;
    assign bus.cc     = cw_gated_c.cc;
    assign bus.mem_rd = cw_gated_c.mem_rd;
    assign bus.mem_wr = cw_gated_c.mem_wr;
    assign bus.halted = cw_gated_c.halted;
    assign bus.buserr = reset ? 1'b0 : buserr_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-cycle expectation queue built from the ISA's
// instruction timing drives reset/mrdy/isr and is checked every cycle.
module tb_control_unit;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_unit_if bus ();

    control_unit #(.TIMEOUT(TO), .TW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [27:0] F_INC  = 28'd1;
    localparam logic [27:0] F_PASS = 28'd2;
    localparam logic [27:0] LSP    = 28'd1 << 3;
    localparam logic [27:0] LPC    = 28'd1 << 4;
    localparam logic [27:0] LMDR   = 28'd1 << 5;
    localparam logic [27:0] LMAR   = 28'd1 << 6;
    localparam logic [27:0] LISR   = 28'd1 << 7;
    localparam logic [27:0] LY     = 28'd1 << 8;
    localparam logic [27:0] WRR    = 28'd1 << 9;
    localparam logic [27:0] TR     = 28'd1 << 10;
    localparam logic [27:0] TSP    = 28'd1 << 11;
    localparam logic [27:0] TPC    = 28'd1 << 12;
    localparam logic [27:0] TMDR   = 28'd1 << 13;
    localparam logic [27:0] TISR   = 28'd1 << 14;
    localparam logic [27:0] SPMAR  = 28'd1 << 15;
    localparam logic [27:0] PCMAR  = 28'd1 << 16;
    localparam logic [27:0] MDRZ   = 28'd1 << 17;
    localparam logic [27:0] MDRM   = 28'd1 << 18;
    localparam logic [27:0] SFLAG  = 28'd1 << 19;
    localparam logic [27:0] CC     = 28'd1 << 20;
    localparam logic [27:0] MEM_RD = 28'd1 << 21;
    localparam logic [27:0] MEM_WR = 28'd1 << 22;
    localparam logic [27:0] HALTED = 28'd1 << 23;
    localparam logic [27:0] BUSERR = 28'd1 << 24;

    logic [27:0] obs;
    assign obs = {bus.rsel, bus.buserr, bus.halted, bus.mem_wr, bus.mem_rd, bus.cc,
                  bus.sflag, bus.mdrm, bus.mdrz, bus.pcmar, bus.spmar, bus.tisr,
                  bus.tmdr, bus.tpc, bus.tsp, bus.tr, bus.wrr, bus.ly, bus.lisr,
                  bus.lmar, bus.lmdr, bus.lpc, bus.lsp, bus.funsel};

    typedef struct {
        logic        rst;
        logic        mrdy;
        logic [15:0] isr;
        logic [27:0] exp;
        int          pin;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_isr = 16'h0000;
    logic        m_err = 1'b0;
    int          total = 0;
    int          bad   = 0;
    int          rd_cnt = 0;
    int          rd_base = 0;

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rst, input logic mrdy, input logic [27:0] strobes, input int pin);
        ent_t e;
        e.rst  = rst;
        e.mrdy = mrdy;
        e.isr  = m_isr;
        e.pin  = pin;
        if (rst) e.exp = '0;
        else     e.exp = strobes | (m_err ? BUSERR : 28'd0) | {m_isr[11:9], 25'd0};
        q.push_back(e);
    endtask

    task automatic do_reset(input int n, input int pin);
        for (int i = 0; i < n; i++) push(1'b1, rnd(), '0, (i == 0) ? pin : 0);
        m_err = 1'b0;
    endtask

    // A request stays up for each mrdy-low cycle; the TO-th such cycle is fatal
    task automatic mem_access(input logic [27:0] req, input logic [27:0] done_extra,
                              input int waits, output bit ok);
        int n;
        n = (waits >= int'(TO)) ? int'(TO) : waits;
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, req, 0);
        if (waits >= int'(TO)) begin
            m_err = 1'b1;
            ok = 1'b0;
        end else begin
            push(1'b0, 1'b1, req | done_extra, 0);
            ok = 1'b1;
        end
    endtask

    task automatic halt_cycles(input int n, input int pin);
        for (int i = 0; i < n; i++) push(1'b0, rnd(), HALTED, (i == 0) ? pin : 0);
    endtask

    task automatic instr(input logic [15:0] ins, input int fw, input int ew,
                         input int pin, input int hn, input int fpin);
        bit ok;
        push(1'b0, rnd(), PCMAR | LMAR, fpin);
        mem_access(MEM_RD, MDRM | LMDR, fw, ok);
        if (ok) begin
            push(1'b0, rnd(), LISR | TPC | LPC | F_INC, 0);
            m_isr = ins;
            push(1'b0, rnd(), '0, 0);
            case (ins[15:12])
                4'h9: begin
                    push(1'b0, rnd(), TR | LY, 0);
                    push(1'b0, rnd(), TISR | WRR | SFLAG, pin);
                end
                4'hA: begin
                    push(1'b0, rnd(), SPMAR | LMAR, 4);
                    mem_access(MEM_RD, MDRM | LMDR, ew, ok);
                    if (ok) push(1'b0, rnd(), TMDR | F_PASS | WRR, pin);
                end
                4'hB: begin
                    push(1'b0, rnd(), TR | F_PASS | MDRZ | LMDR | SPMAR | LMAR, 0);
                    mem_access(MEM_WR, '0, ew, ok);
                end
                4'hC: begin
                    push(1'b0, rnd(), TSP | LY, 0);
                    push(1'b0, rnd(), TISR | LSP, 0);
                end
                4'hD, 4'hE: ;
                4'hF: ok = 1'b0;
                default: begin
                    push(1'b0, rnd(), TPC | LY, 0);
                    push(1'b0, rnd(), TISR | LPC | CC, pin);
                end
            endcase
        end
        if (!ok) halt_cycles(hn, pin);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    initial begin
        do_reset(2, 7);
        instr(16'h9005, 0, 0, 1, 0, 0);
        instr(16'h2FFE, 0, 0, 2, 0, 0);
        instr(16'hA400, 1, 3, 3, 0, 0);   // mrdy arrives on the timeout cycle
        instr(16'hB600, 2, 2, 0, 0, 0);
        instr(16'hC003, 0, 0, 0, 0, 0);
        instr(16'hD000, 0, 0, 0, 0, 0);
        instr(16'hE000, 0, 0, 0, 0, 0);
        instr(16'h0123, 0, 0, 0, 0, 0);
        push(1'b0, rnd(), PCMAR | LMAR, 0);
        push(1'b0, 1'b0, MEM_RD, 0);
        push(1'b0, 1'b0, MEM_RD, 0);
        do_reset(1, 7);
        instr(16'hF000, 0, 0, 8, 20, 6);
        do_reset(1, 7);
        instr(16'hB200, 0, 9, 5, 5, 0);
        do_reset(1, 7);
        instr(16'h9A00, 0, 0, 0, 0, 6);
        instr(16'h9A00, 7, 0, 5, 3, 0);
        do_reset(1, 7);

        for (int i = 0; i < q.size(); i++) begin
            ent_t e;
            e = q[i];
            reset    = e.rst;
            bus.mrdy = e.mrdy;
            bus.isr  = e.isr;
            #2;
            chk("model", 32'(obs), 32'(e.exp));
            if (bus.mem_rd && bus.mem_wr) chk("rd_wr_excl", 32'(1), 32'(0));
            case (e.pin)
                1: chk("addi_i1", 32'({bus.tisr, bus.wrr, bus.sflag, bus.rsel}), 32'(6'b111_000));
                2: chk("branch_b1", 32'({bus.cc, bus.lpc, bus.funsel, bus.tisr}), 32'(6'b1_1_000_1));
                3: begin
                    chk("lds_l2", 32'({bus.tmdr, bus.wrr}), 32'(2'b11));
                    chk("lds_rd_cycles", 32'(rd_cnt - rd_base), 32'(4));
                end
                4: rd_base = rd_cnt;
                5: chk("timeout_halt", 32'({bus.mem_wr, bus.mem_rd, bus.buserr, bus.halted}), 32'(4'b0011));
                6: chk("restart_fadr", 32'({bus.pcmar, bus.lmar}), 32'(2'b11));
                7: chk("reset_zero", 32'(obs), 32'(0));
                8: chk("halt_op", 32'({bus.halted, bus.buserr}), 32'(2'b10));
                default: ;
            endcase
            if (bus.mem_rd) rd_cnt++;
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
